// File: rtl/timer32_pkg.sv
// Shared constants and FSM encoding for the TIMER32 counter engine.
package timer32_pkg;

  localparam int TIMER_WIDTH = 32;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider: emits a one-cycle tick every PRE+1 cycles while running.
module timer_prescaler
  import timer32_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             run,
  input  logic             restart,
  input  logic [WIDTH-1:0] pre,
  output logic             tick
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] pcnt;

  // A PRE rewritten below pcnt lets pcnt wrap through all-ones without ticking.
  assign tick = run && (pcnt == pre);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pcnt <= '0;
    end else if (restart) begin
      pcnt <= '0;
    end else if (run) begin
      if (tick) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + ONE;
      end
    end
  end

endmodule

// File: rtl/timer32_core.sv
// TIMER32 counter engine: run/stop FSM, auto-reloading compare counter and sticky TMROV flag.
module timer32_core
  import timer32_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [WIDTH-1:0] PRE,
  input  logic [WIDTH-1:0] TMRCMP,
  input  logic             TMREN,
  input  logic             TMROVCLR,
  output logic [WIDTH-1:0] TMR,
  output logic             TMROV
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  timer_state_e state;
  timer_state_e state_next;
  logic         run;
  logic         restart;
  logic         tick;
  logic         match;

  // Prescaler only advances on RUN edges that keep running; the stopping edge freezes it.
  assign run     = (state == ST_RUN) && TMREN;
  assign restart = (state == ST_STOP);
  assign match   = tick && (TMR == TMRCMP);

  timer_prescaler #(
    .WIDTH(WIDTH)
  ) u_prescaler (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .run    (run),
    .restart(restart),
    .pre    (PRE),
    .tick   (tick)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= ST_STOP;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_STOP: if (TMREN) state_next = ST_RUN;
      ST_RUN:  if (!TMREN) state_next = ST_STOP;
      default: state_next = ST_STOP;
    endcase
  end

  // Entering RUN always restarts from 0, so a TMREN toggle acts as a restart.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      TMR <= '0;
    end else if ((state == ST_STOP) && TMREN) begin
      TMR <= '0;
    end else if (tick) begin
      if (match) begin
        TMR <= '0;
      end else begin
        TMR <= TMR + ONE;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      TMROV <= 1'b0;
    end else if (TMROVCLR) begin
      TMROV <= 1'b0;
    end else if (match) begin
      TMROV <= 1'b1;
    end
  end

endmodule
